// File: rtl/crc_stream_engine_pkg.sv
// Shared definitions for the CRC stream engine: FSM states plus width-parametrised
// mask and reflect helpers operating on a fixed maximum-width vector.
package crc_stream_engine_pkg;

   localparam int unsigned MAX_W  = 64;
   localparam int unsigned MAX_IW = $clog2(MAX_W);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FINAL = 2'd2
   } state_t;

   // Low w bits set, everything above cleared.
   function automatic logic [MAX_W-1:0] mask_w(input int unsigned w);
      logic [MAX_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         if (i < w) m[MAX_IW'(i)] = 1'b1;
      end
      return m;
   endfunction

   // Bit-reverse the low w bits of v; bits at and above w come back as zero.
   function automatic logic [MAX_W-1:0] reflect_w(input logic [MAX_W-1:0] v, input int unsigned w);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         if (i < w) r[MAX_IW'(i)] = v[MAX_IW'(w - 32'd1 - i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc_parallel_step.sv
// Combinational DATA_WIDTH-deep chain of 1-bit CRC steps under a runtime polynomial and width.
module crc_parallel_step
   import crc_stream_engine_pkg::*;
#(
   parameter  int unsigned CRC_SIZE   = 32,
   parameter  int unsigned DATA_WIDTH = 8,
   localparam int unsigned WW         = $clog2(CRC_SIZE)
) (
   input  logic [CRC_SIZE-1:0]   crc_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [CRC_SIZE-1:0]   crc_poly,
   input  logic [WW-1:0]         crc_width,
   input  logic                  rev_in,
   output logic [CRC_SIZE-1:0]   crc_out
);

   logic [CRC_SIZE-1:0] mask;
   logic [CRC_SIZE-1:0] poly_m;
   logic [CRC_SIZE-1:0] c;
   logic                d;
   logic                fb;

   // Feedback is taken from bit W-1; the mask keeps bits above W at zero.
   always_comb begin
      mask    = CRC_SIZE'(mask_w(32'(crc_width) + 32'd1));
      poly_m  = crc_poly & mask;
      c       = crc_in;
      d       = 1'b0;
      fb      = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         d  = rev_in ? data_in[i] : data_in[DATA_WIDTH-1-i];
         fb = c[crc_width] ^ d;
         c  = ((c << 1) & mask) ^ (fb ? poly_m : '0);
      end
      crc_out = c;
   end

endmodule

// File: rtl/crc_stream_engine.sv
// Frame-level CRC engine: latches config on start, folds one beat per accepted cycle,
// then reflects/XORs the result in a single FINAL cycle.
module crc_stream_engine
   import crc_stream_engine_pkg::*;
#(
   parameter  int unsigned CRC_SIZE   = 32,
   parameter  int unsigned DATA_WIDTH = 8,
   localparam int unsigned WW         = $clog2(CRC_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [CRC_SIZE-1:0]   crc_poly,
   input  logic [WW-1:0]         crc_width,
   input  logic [CRC_SIZE-1:0]   crc_init,
   input  logic [CRC_SIZE-1:0]   xor_out,
   input  logic                  rev_in,
   input  logic                  rev_out,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   input  logic                  data_last,
   output logic                  data_ready,
   output logic                  busy,
   output logic [CRC_SIZE-1:0]   crc_out,
   output logic                  crc_valid
);

   state_t              state;
   logic [CRC_SIZE-1:0] crc_q;
   logic [CRC_SIZE-1:0] poly_q;
   logic [CRC_SIZE-1:0] xor_q;
   logic [WW-1:0]       width_q;
   logic                rev_in_q;
   logic                rev_out_q;

   logic [CRC_SIZE-1:0] step_c;
   logic [CRC_SIZE-1:0] mask_cfg_c;
   logic [CRC_SIZE-1:0] mask_init_c;
   logic [CRC_SIZE-1:0] refl_c;
   logic                accept_c;

   crc_parallel_step #(
      .CRC_SIZE   (CRC_SIZE),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_step (
      .crc_in    (crc_q),
      .data_in   (data_in),
      .crc_poly  (poly_q),
      .crc_width (width_q),
      .rev_in    (rev_in_q),
      .crc_out   (step_c)
   );

   assign mask_cfg_c  = CRC_SIZE'(mask_w(32'(width_q) + 32'd1));
   assign mask_init_c = CRC_SIZE'(mask_w(32'(crc_width) + 32'd1));
   assign refl_c      = CRC_SIZE'(reflect_w(MAX_W'(crc_q), 32'(width_q) + 32'd1));
   assign accept_c    = data_valid & data_ready;

   // start takes priority in every state; data_ready/busy track the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         crc_q      <= '0;
         poly_q     <= '0;
         xor_q      <= '0;
         width_q    <= '0;
         rev_in_q   <= 1'b0;
         rev_out_q  <= 1'b0;
         crc_out    <= '0;
         crc_valid  <= 1'b0;
         busy       <= 1'b0;
         data_ready <= 1'b0;
      end else if (start) begin
         state      <= ST_RUN;
         crc_q      <= crc_init & mask_init_c;
         poly_q     <= crc_poly;
         xor_q      <= xor_out;
         width_q    <= crc_width;
         rev_in_q   <= rev_in;
         rev_out_q  <= rev_out;
         crc_valid  <= 1'b0;
         busy       <= 1'b1;
         data_ready <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               busy       <= 1'b0;
               data_ready <= 1'b0;
            end
            ST_RUN: begin
               if (accept_c) begin
                  crc_q <= step_c;
                  if (data_last) begin
                     state      <= ST_FINAL;
                     data_ready <= 1'b0;
                  end
               end
            end
            ST_FINAL: begin
               crc_out    <= ((rev_out_q ? refl_c : crc_q) ^ xor_q) & mask_cfg_c;
               crc_valid  <= 1'b1;
               state      <= ST_IDLE;
               busy       <= 1'b0;
               data_ready <= 1'b0;
            end
            default: begin
               state      <= ST_IDLE;
               busy       <= 1'b0;
               data_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
